// File: rtl/pool_ch_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_ch_sched_if
// Purpose  : Bundles every non-clock/reset signal of the pooling channel
//            scheduler. This covers the pass control, the feature-memory read
//            port, the pooling-buffer pixel/window path and the pooled-result
//            write port.
// Modports : slave  - the scheduler's view
//            master - the surrounding system's view (controller, feature
//                     memory, pooling buffer and result memory)
// Signals  : start, ch_mask, busy, done, err           pass control
//            rd_en, rd_ch, rd_addr, rd_data             feature-memory read
//            buf_rst_n, pix_out, pool_valid, pool_px    pooling buffer
//            wr_en, wr_ch, wr_addr, wr_data             pooled-result write
// Revision : 1.0 - initial release
// ============================================================================
interface pool_ch_sched_if #(
  parameter int WIDTH  = 26,
  parameter int HEIGHT = 26,
  parameter int NUM_CH = 8
);
  localparam int PIX_N  = WIDTH * HEIGHT;
  localparam int POOL_N = (WIDTH / 2) * (HEIGHT / 2);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = (PIX_N > 1)  ? $clog2(PIX_N)  : 1;
  localparam int POOL_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              buf_rst_n;
  logic              pix_out;
  logic              pool_valid;
  logic [3:0]        pool_px;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [POOL_W-1:0] wr_addr;
  logic              wr_data;

  modport slave (
    input  start, ch_mask, rd_data, pool_valid, pool_px,
    output busy, done, err, rd_en, rd_ch, rd_addr, buf_rst_n, pix_out,
           wr_en, wr_ch, wr_addr, wr_data
  );

  modport master (
    output start, ch_mask, rd_data, pool_valid, pool_px,
    input  busy, done, err, rd_en, rd_ch, rd_addr, buf_rst_n, pix_out,
           wr_en, wr_ch, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/pool_ch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pool_ch_sched
// Purpose  : Channel scheduler for the shared 2x2/stride-2 binary max-pooling
//            line buffer. It walks the enabled channels in ascending order and
//            streams each WIDTHxHEIGHT 1-bit map into the buffer. It resets the
//            buffer between channels and writes the OR of every pooled window
//            to the result memory.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            bus    - pool_ch_sched_if.slave (control, read, buffer, write)
// Revision : 1.0 - initial release
// ============================================================================
module pool_ch_sched #(
  parameter int WIDTH        = 26,
  parameter int HEIGHT       = 26,
  parameter int NUM_CH       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pool_ch_sched_if.slave        bus
);

  localparam int PIX_N  = WIDTH * HEIGHT;
  localparam int POOL_N = (WIDTH / 2) * (HEIGHT / 2);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = (PIX_N > 1)  ? $clog2(PIX_N)  : 1;
  localparam int POOL_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;
  // The pooled counter must be able to hold POOL_N itself (saturation value).
  localparam int PCNT_W = $clog2(POOL_N + 1);
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [NUM_CH-1:0]   r_rem_mask;
  logic [CH_W-1:0]     r_ch;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [DCNT_W-1:0]   r_drain_cnt;
  logic [PCNT_W-1:0]   r_pool_cnt;
  logic                r_rd_vld_d;
  logic                r_buf_rst_n;
  logic                r_err;
  logic                r_wr_en;
  logic [CH_W-1:0]     r_wr_ch;
  logic [POOL_W-1:0]   r_wr_addr;
  logic                r_wr_data;

  logic [CH_W-1:0]     w_low_idx;
  logic                w_rd_en;
  logic                w_pix_last;
  logic                w_drain_last;
  logic                w_start_ok;
  logic                w_pool_take;
  logic                w_pool_room;

  assign w_pix_last   = (r_pix_cnt == ADDR_W'(PIX_N - 1));
  assign w_drain_last = (r_drain_cnt == DCNT_W'(DRAIN_CYCLES - 1));
  assign w_start_ok   = (r_state == S_IDLE) && bus.start;
  // Buffer windows only mean something while the buffer is out of reset.
  assign w_pool_take  = r_buf_rst_n && bus.pool_valid;
  assign w_pool_room  = (r_pool_cnt < PCNT_W'(POOL_N));

  // Lowest set bit of the remaining mask. Scanning downwards lets the lowest
  // index overwrite any higher one.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_rem_mask[i]) begin
        w_low_idx = CH_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and read strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.ch_mask == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = 1'b1;
        if (w_pix_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_state_nxt = (r_rem_mask != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Channel walk, pixel counters and buffer reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_mask  <= '0;
      r_ch        <= '0;
      r_pix_cnt   <= '0;
      r_drain_cnt <= '0;
      r_rd_vld_d  <= 1'b0;
      r_buf_rst_n <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem_mask <= bus.ch_mask;
          end
        end
        S_CLEAR: begin
          r_ch        <= w_low_idx;
          // x & (x-1) drops the lowest set bit, which is the channel just taken.
          r_rem_mask  <= r_rem_mask & (r_rem_mask - NUM_CH'(1));
          r_pix_cnt   <= '0;
          r_drain_cnt <= '0;
        end
        S_STREAM: begin
          r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + DCNT_W'(1);
        end
        default: begin
        end
      endcase
      r_rd_vld_d  <= w_rd_en;
      // The buffer leaves reset on the same edge that the first read data
      // becomes valid, so its first sampled pixel is pixel 0. It is held
      // through the drain so the final windows can still be collected.
      r_buf_rst_n <= (r_state == S_STREAM) ||
                     ((r_state == S_DRAIN) && !w_drain_last);
    end
  end

  // --------------------------------------------------------------------------
  // Result path and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pool_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_ch    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_state == S_CLEAR) begin
        r_pool_cnt <= '0;
      end else if (w_pool_take && w_pool_room) begin
        r_wr_en    <= 1'b1;
        r_wr_data  <= |bus.pool_px;
        r_wr_addr  <= r_pool_cnt[POOL_W-1:0];
        r_wr_ch    <= r_ch;
        r_pool_cnt <= r_pool_cnt + PCNT_W'(1);
      end

      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if ((w_pool_take && !w_pool_room) ||
                   ((r_state == S_DRAIN) && w_drain_last &&
                    (r_pool_cnt != PCNT_W'(POOL_N)))) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_ch     = r_ch;
  assign bus.rd_addr   = w_rd_en ? r_pix_cnt : '0;
  assign bus.buf_rst_n = r_buf_rst_n;
  assign bus.pix_out   = bus.rd_data & r_rd_vld_d;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_ch     = r_wr_ch;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_pool_ch_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pool_ch_sched
// Purpose  : Self-checking bench for pool_ch_sched. It models the feature
//            memory and a 2x2 pooling buffer. Expected reads and pooled writes
//            are derived directly from the stored maps and placed on queues,
//            and a monitor compares every DUT read/write/pixel against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_ch_sched;
  localparam int W       = 26;
  localparam int H       = 26;
  localparam int NCH     = 4;
  localparam int DR      = 4;
  localparam int PIX     = W * H;
  localparam int PN      = (W / 2) * (H / 2);
  localparam int CH_COST = 1 + PIX + DR;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pool_ch_sched_if #(.WIDTH(W), .HEIGHT(H), .NUM_CH(NCH)) bus ();

  pool_ch_sched #(
    .WIDTH(W), .HEIGHT(H), .NUM_CH(NCH), .DRAIN_CYCLES(DR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit fmem [NCH][PIX];
  bit img  [PIX];
  int bcnt;
  int bwin;
  int supp_win = -1;

  typedef struct { int ch; int addr; bit data; } wr_t;
  typedef struct { int ch; int addr; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  bit pv;
  int pch;
  int paddr;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Feature memory: one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? fmem[bus.rd_ch][bus.rd_addr] : 1'($urandom);
  end

  // Pooling buffer: captures pixels in raster order while out of reset and
  // presents each completed 2x2 window the cycle after its last pixel.
  always @(posedge clk) begin
    if (!bus.buf_rst_n) begin
      bcnt           <= 0;
      bwin           <= 0;
      bus.pool_valid <= 1'b0;
      bus.pool_px    <= 4'd0;
    end else begin
      bus.pool_valid <= 1'b0;
      if (bcnt < PIX) begin
        img[bcnt] <= bus.pix_out;
        bcnt      <= bcnt + 1;
        if (((bcnt % W) % 2 == 1) && ((bcnt / W) % 2 == 1)) begin
          bwin <= bwin + 1;
          if (bwin != supp_win) begin
            bus.pool_valid <= 1'b1;
            bus.pool_px    <= {img[bcnt-W-1], img[bcnt-W], img[bcnt-1], bus.pix_out};
          end
        end
      end
    end
  end

  task automatic mon_step();
    rd_t r;
    wr_t w;
    if (!rst_n) begin
      pv = 1'b0;
      return;
    end
    chk("pix_out", longint'(bus.pix_out), pv ? longint'(fmem[pch][paddr]) : 0);
    if (bus.wr_en) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_ch",   longint'(bus.wr_ch),   w.ch);
        chk("wr_addr", longint'(bus.wr_addr), w.addr);
        chk("wr_data", longint'(bus.wr_data), longint'(w.data));
      end
    end
    if (bus.rd_en) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_ch",   longint'(bus.rd_ch),   r.ch);
        chk("rd_addr", longint'(bus.rd_addr), r.addr);
      end
    end
    pv    = bus.rd_en;
    pch   = int'(bus.rd_ch);
    paddr = int'(bus.rd_addr);
  endtask

  // Reference: channels in ascending order, every pixel read in raster
  // order, one write per delivered window holding the OR of its 4 pixels.
  task automatic build_expect(input logic [NCH-1:0] mask);
    int wi;
    int b;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        for (int p = 0; p < PIX; p++) rd_q.push_back('{ch: c, addr: p});
        wi = 0;
        for (int py = 0; py < H / 2; py++) begin
          for (int px = 0; px < W / 2; px++) begin
            if (py * (W / 2) + px != supp_win) begin
              b = int'(fmem[c][2*py*W + 2*px])     + int'(fmem[c][2*py*W + 2*px + 1]) +
                  int'(fmem[c][(2*py+1)*W + 2*px]) + int'(fmem[c][(2*py+1)*W + 2*px + 1]);
              wr_q.push_back('{ch: c, addr: wi, data: (b != 0)});
              wi++;
            end
          end
        end
      end
    end
  endtask

  task automatic issue_start(input logic [NCH-1:0] mask);
    @(negedge clk);
    bus.ch_mask = mask;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.ch_mask = NCH'($urandom);
  endtask

  task automatic run_pass(input logic [NCH-1:0] mask, input bit exp_err,
                          input int extra_start_cyc);
    int  exp_done;
    int  n;
    int  busy_bad;
    bit  got_done;
    exp_done = 1 + $countones(mask) * CH_COST;
    busy_bad = 0;
    got_done = 1'b0;
    build_expect(mask);
    issue_start(mask);
    n = 1;
    while (!got_done && n <= exp_done + 20) begin
      @(negedge clk);
      if (bus.busy != (n < exp_done)) busy_bad++;
      if (n == 1) chk("err_clear_on_start", longint'(bus.err), 0);
      if (bus.done) begin
        got_done = 1'b1;
        chk("done_cycle", n, exp_done);
        chk("err_at_done", longint'(bus.err), longint'(exp_err));
      end
      if (n == extra_start_cyc) begin
        bus.start   = 1'b1;
        bus.ch_mask = '1;
      end else begin
        bus.start = 1'b0;
      end
      n++;
    end
    bus.start = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("busy_window_errors", busy_bad, 0);
    repeat (3) @(negedge clk);
    chk("writes_outstanding", wr_q.size(), 0);
    chk("reads_outstanding", rd_q.size(), 0);
    chk("err_sticky_after_done", longint'(bus.err), longint'(exp_err));
    chk("idle_after_done", longint'({bus.busy, bus.done}), 0);
    wr_q.delete();
    rd_q.delete();
  endtask

  function automatic longint out_vec();
    return longint'({bus.busy, bus.done, bus.err, bus.rd_en, bus.rd_ch, bus.rd_addr,
                     bus.buf_rst_n, bus.pix_out, bus.wr_en, bus.wr_ch, bus.wr_addr,
                     bus.wr_data});
  endfunction

  task automatic fill_random(input int density);
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < PIX; p++)
        fmem[c][p] = ($urandom_range(99) < density);
  endtask

  task automatic main_seq();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", out_vec(), 0);

    // Single channel, all ones
    for (int c = 0; c < NCH; c++) for (int p = 0; p < PIX; p++) fmem[c][p] = 1'b1;
    run_pass(4'b0001, 1'b0, -1);

    // Single set pixel at (3,5): window 27 is the only 1
    for (int c = 0; c < NCH; c++) for (int p = 0; p < PIX; p++) fmem[c][p] = 1'b0;
    fmem[0][5 * W + 3] = 1'b1;
    run_pass(4'b0001, 1'b0, -1);

    // Sparse mask with an ignored start during the pass
    fill_random(20);
    run_pass(4'b1010, 1'b0, 300);

    // Empty mask
    run_pass(4'b0000, 1'b0, -1);

    // Count mismatch, then a clean pass clears err
    fill_random(50);
    supp_win = 50;
    run_pass(4'b0100, 1'b1, -1);
    supp_win = -1;
    run_pass(4'b0001, 1'b0, -1);

    // Random masks and data
    for (int t = 0; t < 2; t++) begin
      fill_random(int'($urandom_range(5, 60)));
      run_pass(NCH'($urandom_range(1, (1 << NCH) - 1)), 1'b0, -1);
    end

    // Mid-stream asynchronous reset
    fill_random(30);
    build_expect(4'b0011);
    issue_start(4'b0011);
    repeat (399) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midpass_reset_outputs", out_vec(), 0);
    chk("midpass_buf_rst_n", longint'(bus.buf_rst_n), 0);
    wr_q.delete();
    rd_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", out_vec(), 0);
    run_pass(4'b0001, 1'b0, -1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.ch_mask = '0;
    fork
      begin
        forever begin
          @(negedge clk);
          mon_step();
        end
      end
      begin
        main_seq();
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
